// File: rtl/line_window_buffer_pkg.sv
// Shared defaults, the counter-width helper and the pixel type for the line window buffer.
package lwb_pkg;

  localparam int LWB_PIX_W    = 8;
  localparam int LWB_LINE_W   = 640;
  localparam int LWB_NUM_ROWS = 3;

  // Width needed to index n entries; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef logic [LWB_PIX_W-1:0] pixel_t;

endpackage

// File: rtl/line_window_buffer_line_ram.sv
// Single-port line store: registered read of the old word, then write, on the same enable.
module line_ram #(
  parameter int PIX_W  = 8,
  parameter int LINE_W = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [PIX_W-1:0]  wdata_i,
  output logic [PIX_W-1:0]  rdata_o
);

  logic [PIX_W-1:0] mem_q [LINE_W];
  logic [PIX_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      rdata_q <= mem_q[addr_i];
      if (we_i) mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_window_buffer.sv
// Multi-line window buffer: presents a NUM_ROWS-high pixel column per accepted pixel.
// Optional build macro LWB_BORDER_REPLICATE_EN replicates the newest filled row into unfilled slices.
module line_window_buffer
  import lwb_pkg::*;
#(
  parameter int PIX_W    = LWB_PIX_W,
  parameter int LINE_W   = LWB_LINE_W,
  parameter int NUM_ROWS = LWB_NUM_ROWS,
  parameter int COL_W    = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sof,
  input  logic                      wr_en,
  input  logic [PIX_W-1:0]          pixel,
  output logic [NUM_ROWS*PIX_W-1:0] taps,
  output logic [COL_W-1:0]          tap_col,
  output logic                      tap_valid,
  output logic                      line_done,
  output logic [COL_W-1:0]          lines_filled
);

  localparam int R     = NUM_ROWS - 1;
  localparam int ROW_W = cnt_w(R);
  localparam int AW    = cnt_w(LINE_W);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);
  localparam logic [COL_W-1:0] FULL     = COL_W'(R);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(R - 1);

  logic [COL_W-1:0] col_q, col_d, col_e;
  logic [ROW_W-1:0] row_q, row_d, row_e;
  logic [COL_W-1:0] fill_q, fill_d, fill_e;
  logic [COL_W-1:0] tap_col_q;
  logic             tap_valid_q, line_done_q;
  logic [PIX_W-1:0] pix_q;
  logic [R-1:0]     mask_q, mask_d, live_q, live_d;
  logic [ROW_W-1:0] src_row_q [R];
  logic [ROW_W-1:0] src_row_d [R];
  logic [PIX_W-1:0] rd [R];
  logic             eol;

  // sof clears the pointers before they are used this cycle
  assign col_e  = sof ? '0 : col_q;
  assign row_e  = sof ? '0 : row_q;
  assign fill_e = sof ? '0 : fill_q;
  assign eol    = (col_e == LAST_COL);

  always_comb begin
    col_d  = col_e;
    row_d  = row_e;
    fill_d = fill_e;
    if (wr_en) begin
      if (eol) begin
        col_d  = '0;
        row_d  = (row_e == LAST_ROW) ? '0 : row_e + 1'b1;
        fill_d = (fill_e == FULL) ? fill_e : fill_e + 1'b1;
      end else begin
        col_d = col_e + 1'b1;
      end
    end
  end

  // Slot k (1 = newest stored line) maps to ring row wr_row-k; s is the slot actually sourced.
  always_comb begin
    int s, r;
    s = 0;
    r = 0;
    mask_d = '0;
    live_d = '0;
    for (int i = 0; i < R; i++) begin
      s = i + 1;
`ifdef LWB_BORDER_REPLICATE_EN
      if (s > int'(fill_e)) s = int'(fill_e);
      live_d[i] = (s == 0);
`else
      mask_d[i] = (s > int'(fill_e));
`endif
      r = int'(row_e) - s;
      if (r < 0) r = r + R;
      src_row_d[i] = ROW_W'(r);
    end
  end

  for (genvar g = 0; g < R; g++) begin : g_row
    line_ram #(
      .PIX_W (PIX_W),
      .LINE_W(LINE_W),
      .ADDR_W(AW)
    ) u_ram (
      .clk    (clk),
      .en_i   (wr_en),
      .we_i   (wr_en && (row_e == ROW_W'(g))),
      .addr_i (col_e[AW-1:0]),
      .wdata_i(pixel),
      .rdata_o(rd[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      fill_q      <= '0;
      tap_col_q   <= '0;
      tap_valid_q <= 1'b0;
      line_done_q <= 1'b0;
      pix_q       <= '0;
      mask_q      <= '1;
      live_q      <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      fill_q      <= fill_d;
      line_done_q <= wr_en && eol;
`ifdef LWB_BORDER_REPLICATE_EN
      tap_valid_q <= wr_en;
`else
      tap_valid_q <= wr_en && (fill_e == FULL);
`endif
      if (wr_en) begin
        tap_col_q <= col_e;
        pix_q     <= pixel;
        mask_q    <= mask_d;
        live_q    <= live_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) src_row_q <= src_row_d;
  end

  // Stored slices come straight from the RAM read registers, aligned with pix_q.
  always_comb begin
    taps = '0;
    taps[PIX_W-1:0] = pix_q;
    for (int i = 0; i < R; i++) begin
      if (mask_q[i])      taps[(i+1)*PIX_W +: PIX_W] = '0;
      else if (live_q[i]) taps[(i+1)*PIX_W +: PIX_W] = pix_q;
      else                taps[(i+1)*PIX_W +: PIX_W] = rd[src_row_q[i]];
    end
  end

  assign tap_col      = tap_col_q;
  assign tap_valid    = tap_valid_q;
  assign line_done    = line_done_q;
  assign lines_filled = fill_q;

endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer with LINE_W=4, NUM_ROWS=3; honours LWB_BORDER_REPLICATE_EN.
module tb_line_window_buffer;
  import lwb_pkg::*;

  localparam int PW = 8;
  localparam int LW = 4;
  localparam int NR = 3;
  localparam int CW = 3;

  logic             clk = 1'b0;
  logic             rst, sof, wr_en;
  pixel_t           pixel;
  logic [NR*PW-1:0] taps;
  logic [CW-1:0]    tap_col;
  logic             tap_valid, line_done;
  logic [CW-1:0]    lines_filled;

  int n_chk  = 0;
  int n_pass = 0;

  line_window_buffer #(
    .PIX_W(PW), .LINE_W(LW), .NUM_ROWS(NR), .COL_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .sof(sof), .wr_en(wr_en), .pixel(pixel),
    .taps(taps), .tap_col(tap_col), .tap_valid(tap_valid),
    .line_done(line_done), .lines_filled(lines_filled)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  // Expected column for line l of the frame with live pixel p (lines are 4 consecutive values).
  function automatic logic [23:0] exp_taps(input int l, input int p);
    int k1, k2;
`ifdef LWB_BORDER_REPLICATE_EN
    k1 = (l >= 1) ? p - 4 : p;
    k2 = (l >= 2) ? p - 8 : k1;
`else
    k1 = (l >= 1) ? p - 4 : 0;
    k2 = (l >= 2) ? p - 8 : 0;
`endif
    return {k2[7:0], k1[7:0], p[7:0]};
  endfunction

  function automatic logic exp_valid(input int l);
`ifdef LWB_BORDER_REPLICATE_EN
    return 1'b1;
`else
    return l >= 2;
`endif
  endfunction

  task automatic push(input int p, input bit s);
    pixel = PW'(p);
    wr_en = 1'b1;
    sof   = s;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    sof   = 1'b0;
  endtask

  task automatic check_pix(input int l, input int c, input int p, input int fill);
    check($sformatf("taps p%0d", p),  32'(taps), 32'(exp_taps(l, p)));
    check($sformatf("col p%0d", p),   32'(tap_col), 32'(c));
    check($sformatf("valid p%0d", p), 32'(tap_valid), 32'(exp_valid(l)));
    check($sformatf("done p%0d", p),  32'(line_done), 32'(c == LW - 1));
    check($sformatf("fill p%0d", p),  32'(lines_filled), 32'(fill));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " taps"},  32'(taps), 32'd0);
    check({tag, " col"},   32'(tap_col), 32'd0);
    check({tag, " valid"}, 32'(tap_valid), 32'd0);
    check({tag, " done"},  32'(line_done), 32'd0);
    check({tag, " fill"},  32'(lines_filled), 32'd0);
  endtask

  task automatic run_frame(input int nlines, input int gap);
    int p, f;
    for (int l = 0; l < nlines; l++) begin
      for (int c = 0; c < LW; c++) begin
        p = l * LW + c + 1;
        f = l + ((c == LW - 1) ? 1 : 0);
        if (f > NR - 1) f = NR - 1;
        push(p, (l == 0) && (c == 0));
        check_pix(l, c, p, f);
        for (int g = 0; g < gap; g++) begin
          @(posedge clk);
          #1;
          check($sformatf("gap valid p%0d", p), 32'(tap_valid), 32'd0);
          check($sformatf("gap done p%0d", p),  32'(line_done), 32'd0);
          check($sformatf("gap taps p%0d", p),  32'(taps), 32'(exp_taps(l, p)));
          check($sformatf("gap col p%0d", p),   32'(tap_col), 32'(c));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; sof = 1'b0; wr_en = 1'b0; pixel = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("reset");

    // three lines then a fourth to rotate the ring
    run_frame(4, 0);

    // same stream with idle gaps between pixels
    run_frame(3, 2);

    // sof mid-line abandons the partial line
    run_frame(2, 0);
    push(9, 1'b0);
    push(10, 1'b0);
    for (int c = 0; c < LW; c++) begin
      push(20 + c, c == 0);
      check_pix(0, c, 20 + c, (c == LW - 1) ? 1 : 0);
    end

    // reset in the middle of line 2
    run_frame(1, 0);
    push(5, 1'b0);
    push(6, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_zero("midrst");
    run_frame(3, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
